// File: rtl/ifu_fetch_pkg.sv
// Shared P5 pipeline definitions for the fetch stage: reset constants,
// fetch state encoding and the F/D register bundle.
package ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_DEF      = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        adel;
    } fd_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory handshake: one request/grant pair and a response word.
interface ifu_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/ifu_fetch_buf.sv
// One-entry holding register for a fetched word that arrived while decode
// was stalled. Load and clear never coincide: a load happens only in WAIT
// under stall, a clear only on an advance.
module fetch_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        valid_o
);

    logic [31:0] data_q;
    logic        valid_q;

    // Capture the returned word on load; drop the entry once it is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ifu_fetch.sv
// P5 fetch stage: owns the PC, fetches one instruction at a time over the
// req/gnt/rvalid handshake, buffers a word while decode is stalled and
// drives the F/D register. Redirects come only through npc (delay slot),
// so nothing already fetched is ever flushed.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP      = NOP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [31:0]        npc,
    output logic [31:0]        f_pc,
    ifu_fetch_if.master        imem,
    output logic [31:0]        d_instr,
    output logic [31:0]        d_pc,
    output logic               d_valid,
    output logic               d_adel,
    output logic               fetch_busy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    fd_t          fd_q, fd_d;

    logic [31:0]  buf_data;
    logic         buf_valid;
    logic         aligned;
    logic         misaligned_req;
    logic         resp_now;
    logic         avail;
    logic         advance;
    logic         buf_load;
    logic [31:0]  word;

    assign aligned        = (pc_q[1:0] == 2'b00);
    assign misaligned_req = (state_q == ST_REQ) && !aligned;
    assign resp_now       = (state_q == ST_WAIT) && imem.imem_rvalid;
    assign avail          = resp_now || ((state_q == ST_HOLD) && buf_valid);
    assign advance        = avail && !stall;
    assign buf_load       = resp_now && stall;
    assign word           = (state_q == ST_HOLD) ? buf_data : imem.imem_rdata;

    fetch_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .load_i  (buf_load),
        .clear_i (advance),
        .data_i  (imem.imem_rdata),
        .data_o  (buf_data),
        .valid_o (buf_valid)
    );

    // State, PC and F/D registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            fd_q    <= '{instr: NOP, pc: 32'h0, valid: 1'b0, adel: 1'b0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fd_q    <= fd_d;
        end
    end

    // Next state, next PC and F/D load; defaults hold everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fd_d    = fd_q;

        unique case (state_q)
            ST_REQ: begin
                if (aligned && imem.imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rvalid) begin
                    state_d = stall ? ST_HOLD : ST_REQ;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        if (!stall) begin
            if (advance) begin
                fd_d = '{instr: word, pc: pc_q, valid: 1'b1, adel: 1'b0};
                pc_d = npc;
            end else if (misaligned_req) begin
                // No request goes out; the exception travels down as a bubble.
                fd_d = '{instr: NOP, pc: pc_q, valid: 1'b0, adel: 1'b1};
                pc_d = npc;
            end else begin
                fd_d = '{instr: NOP, pc: pc_q, valid: 1'b0, adel: 1'b0};
            end
        end
    end

    assign imem.imem_req  = (state_q == ST_REQ) && aligned;
    assign imem.imem_addr = pc_q;

    assign f_pc       = pc_q;
    assign d_instr    = fd_q.instr;
    assign d_pc       = fd_q.pc;
    assign d_valid    = fd_q.valid;
    assign d_adel     = fd_q.adel;
    assign fetch_busy = ((state_q == ST_REQ) && aligned) || (state_q == ST_WAIT);

endmodule
